// File: rtl/dbg_uart_tx.sv
// dbg_uart_tx: debug-port UART transmitter, byte FIFO feeding an 8N1 serialiser (8E1 when DBG_UART_PARITY_EN is defined)
module dbg_uart_tx #(
  parameter int CLK_HZ     = 18000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       busy
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW = DIV < 2 ? 1 : $clog2(DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
  if (DIV < 2) begin : g_div_chk
    $error("dbg_uart_tx: CLK_HZ/BAUD must be at least 2");
  end
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef DBG_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] lvl_q, lvl_d;
  logic ready_q, tx_q, busy_q, line_d, push, pop, wrap, empty;
  assign push = tx_valid && ready_q;
  assign empty = lvl_q == '0;
  assign wrap = cnt_q == CNT_MAX;
  assign pop = !empty && (state_q == S_IDLE || (state_q == S_STOP && wrap));
  assign lvl_d = lvl_q + (AW+1)'(push) - (AW+1)'(pop);
  assign tx_ready = ready_q;
  assign uart_tx = tx_q;
  assign busy = busy_q;
  // Next state: load a byte from IDLE or straight from the end of STOP, advance one bit per baud wrap
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == S_IDLE || wrap) ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    byte_d = pop ? mem_q[rd_q] : byte_q;
    case (state_q)
      S_IDLE:   state_d = pop ? S_START : S_IDLE;
      S_START:  if (wrap) state_d = S_DATA;
      S_DATA:   if (wrap) begin
                  bit_d = bit_q + 3'd1;
`ifdef DBG_UART_PARITY_EN
                  if (bit_q == 3'd7) state_d = S_PARITY;
`else
                  if (bit_q == 3'd7) state_d = S_STOP;
`endif
                end
`ifdef DBG_UART_PARITY_EN
      S_PARITY: if (wrap) state_d = S_STOP;
`endif
      S_STOP:   if (wrap) state_d = pop ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    line_d = state_q == S_START ? 1'b0 : state_q == S_DATA ? byte_q[bit_q] : 1'b1;
`ifdef DBG_UART_PARITY_EN
    if (state_q == S_PARITY) line_d = ^byte_q;
`endif
  end
  // Control, FIFO pointers and the line register; reset aborts any frame and idles the line high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      ready_q <= 1'b1;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      lvl_q <= lvl_d;
      ready_q <= lvl_d != LVL_FULL;
      tx_q <= line_d;
      busy_q <= push || !empty || state_q != S_IDLE;
    end
  end
  // FIFO storage; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= tx_data;
  end
endmodule
